mdu_riscv: RTL and testbench
============================

# mdu_riscv

Iterative RV32M multiply/divide unit that sits beside `alu_riscv` in the execute stage. It accepts one operation through a request/ready handshake and computes it over several cycles. It returns the 32-bit result with a one-cycle `valid_o` pulse. The core stalls on `ready_o` low; operation encoding equals the instruction's funct3.

## Interface
- No parameters.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  start request; accepted on an edge where `req_i && ready_o`.
- `mdu_op_i`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a_i`  in  32  rs1 operand; sampled only on accept.
- `b_i`  in  32  rs2 operand; sampled only on accept.
- `ready_o`  out  1  high only in IDLE.
- `valid_o`  out  1  result valid; one-cycle pulse.
- `result_o`  out  32  result; holds its last value until the next completion.

## Operation
- **States.**
  - IDLE: `ready_o`=1; on accept, latch operands, op and sign info.
  - From IDLE, go to DONE if early-out applies, else to BUSY.
  - BUSY: 5-bit counter runs 0..31, one iteration per cycle; leaves for DONE when the counter hits 31.
  - DONE: `valid_o`=1 and `result_o` updated; always returns to IDLE on the next edge.
- **Sign handling.**
  - Signed operands (MULH/DIV/REM both; MULHSU `a` only) are converted to magnitude before iteration.
  - Result is negated at the end when required: product/quotient sign = sa^sb; remainder sign = sa.
- **Multiply.** Radix-2 shift-add on 32-bit magnitudes into a 64-bit accumulator.
  - MUL returns bits [31:0].
  - MULH, MULHSU and MULHU return bits [63:32] of the correctly signed 64-bit product.
- **Divide.** Restoring, one quotient bit per iteration, with a 33-bit partial remainder.
- **Early-out (no BUSY).**
  - Divisor 0: quotient = 32'hFFFFFFFF; remainder = `a_i`. Applies to signed and unsigned.
  - DIV/REM with `a`=32'h80000000 and `b`=32'hFFFFFFFF: quotient = 32'h80000000; remainder = 0.
- **Handshake.**
  - `req_i` is ignored while `ready_o`=0; it is never queued.
  - `req_i` held high in IDLE starts back-to-back operations.
  - Operands and op may change freely after accept.

## Timing
- **Reset values.** All outputs settle immediately on `rst_ni` low: `ready_o`=1, `valid_o`=0, `result_o`=0, state IDLE, counter 0.
- **Reset mid-operation.** Aborts the operation. No `valid_o` is produced.
- **Latency.** Accept edge E0.
  - Iterative op: BUSY after E0, DONE after E0+32, so `valid_o` is high in the cycle following edge E0+32.
  - `ready_o` returns after E0+33.
  - Early-out: `valid_o` in the cycle after E0; `ready_o` after E0+1.
- **Throughput.**
  - Iterative: one op per 34 cycles.
  - Early-out: one op per 2 cycles.
- **Pulse behaviour.** `valid_o` is never high for two consecutive cycles.

## Configuration
- `MDU_FAST_MUL_EN`
  - **Defined:** all four multiply ops use a single-cycle 33x33 signed multiplier. They take the early-out path: DONE after E0, latency 1, no BUSY.
  - **Undefined:** multiplies iterate through BUSY, 32 cycles.
  - **Unaffected:** division timing is identical either way, and results are bit-identical.

## Test plan
- **Reset mid-op.** Reset asserted asynchronously mid-clock, with a DIVU in BUSY → outputs immediately read `ready_o`=1, `valid_o`=0, `result_o`=0. After release, no `valid_o` appears.
- **Multiply variants** on `a`=32'hFFFFFFFE, `b`=32'h00000003:
  - MUL → 32'hFFFFFFFA
  - MULH → 32'hFFFFFFFF
  - MULHU → 32'h00000002
  - MULHSU → 32'hFFFFFFFF
  - Iterative build: each `valid_o` is exactly 33 edges after accept. With `MDU_FAST_MUL_EN`: 1 edge after accept.
- **Signed divide.** DIV `a`=-7 (32'hFFFFFFF9), `b`=2 → 32'hFFFFFFFD. REM, same operands → 32'hFFFFFFFF. DIVU 32'hFFFFFFF9 / 2 → 32'h7FFFFFFC. Latency 33 edges each.
- **Divide by zero.** Divisor 0: DIV 5/0 → 32'hFFFFFFFF; REMU 5/0 → 32'h00000005. Overflow case DIV 32'h80000000 / 32'hFFFFFFFF → 32'h80000000, and REM of the same operands → 0. All with `valid_o` one cycle after accept.
- **Handshake.** `req_i` held high for 100 cycles with MUL 3*4 → `req_i` is ignored while busy. A new op starts only when `ready_o`=1, each `valid_o` pulse lasts one cycle with result 32'h0000000C, and `result_o` holds between pulses.

Source files
------------

// File: rtl/mdu_riscv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle one.
module mdu_riscv (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [2:0]  mdu_op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [31:0] res_q, res_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;

    logic        is_div, a_sgn, b_sgn, sa, sb;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, early;
    logic [31:0] early_res;

`ifdef MDU_FAST_MUL_EN
    logic signed [32:0] fa, fb;
    logic signed [63:0] fp;
`endif

    always_comb begin
        is_div    = mdu_op_i[2];
        a_sgn     = (mdu_op_i == OP_MULH) || (mdu_op_i == OP_MULHSU)
                 || (mdu_op_i == OP_DIV)  || (mdu_op_i == OP_REM);
        b_sgn     = (mdu_op_i == OP_MULH) || (mdu_op_i == OP_DIV)
                 || (mdu_op_i == OP_REM);
        sa        = a_sgn & a_i[31];
        sb        = b_sgn & b_i[31];
        a_mag     = sa ? -a_i : a_i;
        b_mag     = sb ? -b_i : b_i;
        div_zero  = is_div && (b_i == 32'h0);
        div_ovf   = ((mdu_op_i == OP_DIV) || (mdu_op_i == OP_REM))
                 && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
        early     = div_zero || div_ovf;
        early_res = 32'h0;
        if (div_zero) begin
            early_res = mdu_op_i[1] ? a_i : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            early_res = mdu_op_i[1] ? 32'h0 : 32'h8000_0000;
        end
`ifdef MDU_FAST_MUL_EN
        fa = {sa, a_i};
        fb = {sb, b_i};
        fp = fa * fb;
        if (!is_div) begin
            early     = 1'b1;
            early_res = (mdu_op_i == OP_MUL) ? fp[31:0] : fp[63:32];
        end
`endif
    end

    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] div_shl;
    logic [33:0] div_dif;
    logic        div_bit;
    logic [31:0] div_rem;
    logic [63:0] div_nxt;
    logic [63:0] step, prod;
    logic [31:0] quo, rem, fin_res;
    logic        unused_dif;

    // acc holds {hi, multiplier} for MUL ops and {remainder, dividend/quotient} for DIV ops
    always_comb begin
        mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_nxt    = {mul_sum, acc_q[31:1]};
        div_shl    = {acc_q[63:32], acc_q[31]};
        div_dif    = {1'b0, div_shl} - {2'b00, opb_q};
        div_bit    = ~div_dif[33];
        div_rem    = div_bit ? div_dif[31:0] : div_shl[31:0];
        div_nxt    = {div_rem, acc_q[30:0], div_bit};
        unused_dif = div_dif[32];
        step       = op_q[2] ? div_nxt : mul_nxt;
        prod       = negq_q ? -step : step;
        quo        = negq_q ? -step[31:0] : step[31:0];
        rem        = negr_q ? -step[63:32] : step[63:32];
        if (op_q[2]) begin
            fin_res = op_q[1] ? rem : quo;
        end else begin
            fin_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    op_d   = mdu_op_i;
                    negq_d = sa ^ sb;
                    negr_d = sa;
                    acc_d  = {32'h0, a_mag};
                    opb_d  = b_mag;
                    cnt_d  = 5'd0;
                    if (early) begin
                        res_d   = early_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                acc_d = step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    res_d   = fin_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 3'd0;
            acc_q   <= 64'h0;
            opb_q   <= 32'h0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= 32'h0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = res_q;

endmodule

// File: tb/tb_mdu_riscv.sv
// Scoreboard bench for mdu_riscv: random and directed RV32M ops checked
// against a plain-arithmetic reference model, including latency and handshake.
module tb_mdu_riscv;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic [2:0]  mdu_op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;

    mdu_riscv dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .mdu_op_i (mdu_op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        em;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          npulse = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] last_res = 32'h0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] ref_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int          sa, sbv;
        longint      pa, pb;
        logic [63:0] pu;
        logic        ovf;
        sa  = a;
        sbv = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin pu = {32'h0, a} * {32'h0, b}; return pu[31:0]; end
            3'd1: begin pa = sa; pb = sbv; pu = pa * pb; return pu[63:32]; end
            3'd2: begin
                pa = sa; pb = longint'({32'h0, b}); pu = pa * pb;
                return pu[63:32];
            end
            3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sbv);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sbv);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && b == 0) return 0;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 0;
`ifdef MDU_FAST_MUL_EN
        if (!op[2]) return 0;
`endif
        return 32;
    endfunction

    // Observer pushes expectations on accept; monitor pops on each valid pulse.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            last_res   = 32'h0;
            prev_valid = 1'b0;
        end else begin
            if (valid_o) begin
                npulse++;
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL valid_pulse: valid_o high two cycles at cyc %0d", cyc);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: result=%h with empty scoreboard", result_o);
                end else begin
                    em = sb.pop_front();
                    if (result_o !== em.res) begin
                        errors++;
                        $display("FAIL result: got %h required %h", result_o, em.res);
                    end
                    checks++;
                    if (cyc - em.acc != em.lat) begin
                        errors++;
                        $display("FAIL latency: got %0d required %0d", cyc - em.acc, em.lat);
                    end
                end
                last_res = result_o;
            end else begin
                checks++;
                if (result_o !== last_res) begin
                    errors++;
                    $display("FAIL result_hold: got %h required %h", result_o, last_res);
                end
            end
            prev_valid = valid_o;
            if (req_i && ready_o)
                sb.push_back('{ref_res(mdu_op_i, a_i, b_i), cyc + 1,
                               ref_lat(mdu_op_i, a_i, b_i)});
        end
    end

    task automatic check1(input string name, input logic [31:0] got,
                          input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int t = 0;
        @(posedge clk_i); #1;
        while (!ready_o && t < 100) begin
            @(posedge clk_i); #1;
            t++;
        end
        check1("issue_ready", {31'h0, ready_o}, 32'h1);
        mdu_op_i = op;
        a_i      = a;
        b_i      = b;
        req_i    = 1'b1;
        @(posedge clk_i); #1;
        req_i    = 1'b0;
        mdu_op_i = 3'($urandom);
        a_i      = $urandom;
        b_i      = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk_i);
            t++;
        end
        check1("drain", sb.size(), 0);
    endtask

    logic [2:0]  d_op[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6,
                              3'd5, 3'd4, 3'd7, 3'd4, 3'd6, 3'd5};
    logic [31:0] d_a[12]  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE,
                              32'hFFFFFFFE, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'hFFFFFFF9, 32'h5, 32'h5, 32'h80000000,
                              32'h80000000, 32'h5};
    logic [31:0] d_b[12]  = '{32'h3, 32'h3, 32'h3, 32'h3, 32'h2, 32'h2,
                              32'h2, 32'h0, 32'h0, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h0};

    initial begin
        logic [31:0] ra, rb;
        int          p0;
        rst_ni   = 1'b1;
        req_i    = 1'b0;
        mdu_op_i = 3'd0;
        a_i      = 32'h0;
        b_i      = 32'h0;
        #1 rst_ni = 1'b0;
        #2;
        check1("rst_ready", {31'h0, ready_o}, 32'h1);
        check1("rst_valid", {31'h0, valid_o}, 32'h0);
        check1("rst_result", result_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        for (int i = 0; i < 12; i++) issue(d_op[i], d_a[i], d_b[i]);
        drain();

        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 200) - 100; rb = $urandom_range(1, 9); end
                3: rb = -rb[15:0];
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            issue(3'($urandom), ra, rb);
        end
        drain();

        p0 = npulse;
        @(posedge clk_i); #1;
        mdu_op_i = 3'd0;
        a_i      = 32'd3;
        b_i      = 32'd4;
        req_i    = 1'b1;
        repeat (100) @(posedge clk_i);
        #1 req_i = 1'b0;
        drain();
        checks++;
        if (npulse - p0 < 2) begin
            errors++;
            $display("FAIL hold_pulses: got %0d required at least 2", npulse - p0);
        end

        issue(3'd5, 32'd1000, 32'd7);
        repeat (10) @(posedge clk_i);
        #1;
        check1("busy_ready", {31'h0, ready_o}, 32'h0);
        #2 rst_ni = 1'b0;
        #1;
        check1("midrst_ready", {31'h0, ready_o}, 32'h1);
        check1("midrst_valid", {31'h0, valid_o}, 32'h0);
        check1("midrst_result", result_o, 32'h0);
        sb.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (50) @(posedge clk_i);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
